// File: rtl/watch_pkg.sv
// Shared encodings, field ranges and helpers for the watch timekeeper.
package watch_pkg;

  localparam logic [1:0] SEL_SEC  = 2'd0;
  localparam logic [1:0] SEL_MIN  = 2'd1;
  localparam logic [1:0] SEL_HOUR = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

  typedef enum logic [1:0] {
    ALM_OFF   = 2'd0,
    ALM_ARMED = 2'd1,
    ALM_RING  = 2'd2
  } alm_state_e;

  // Modulo step of a field in 0..max_v, no carry out.
  function automatic logic [5:0] step(input logic [5:0] v, input logic [5:0] max_v,
                                      input logic up);
    if (up) return (v == max_v) ? 6'd0 : v + 6'd1;
    return (v == 6'd0) ? max_v : v - 6'd1;
  endfunction

  function automatic logic [4:0] fmt_hour(input logic [4:0] h, input logic mode12);
    if (!mode12)     return h;
    if (h == 5'd0)   return 5'd12;
    if (h > 5'd12)   return h - 5'd12;
    return h;
  endfunction

endpackage

// File: rtl/watch_timekeeper_if.sv
// Control/display bundle between the watch control unit and the timekeeper.
interface watch_timekeeper_if #(
  parameter int TICK_HZ = 100
);
  localparam int MSW = $clog2(TICK_HZ);

  logic           i_run;
  logic           i_target;
  logic [1:0]     i_sel;
  logic           i_up;
  logic           i_down;
  logic           i_mode12;
  logic           i_alarm_en;
  logic           i_alarm_ack;
  logic [MSW-1:0] o_msec;
  logic [5:0]     o_sec;
  logic [5:0]     o_min;
  logic [4:0]     o_hour;
  logic           o_pm;
  logic [5:0]     o_alm_min;
  logic [4:0]     o_alm_hour;
  logic           o_ring;
  logic           o_sec_tick;

  modport master (
    output i_run, i_target, i_sel, i_up, i_down, i_mode12, i_alarm_en, i_alarm_ack,
    input  o_msec, o_sec, o_min, o_hour, o_pm, o_alm_min, o_alm_hour, o_ring, o_sec_tick
  );

  modport slave (
    input  i_run, i_target, i_sel, i_up, i_down, i_mode12, i_alarm_en, i_alarm_ack,
    output o_msec, o_sec, o_min, o_hour, o_pm, o_alm_min, o_alm_hour, o_ring, o_sec_tick
  );

endinterface

// File: rtl/watch_tick_gen.sv
// Clock divider with enable; tick is high for the one cycle the count sits at DIV-1.
module watch_tick_gen #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // A stopped divider parked on LAST must not keep firing.
  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/watch_timekeeper.sv
// Time-of-day cascade with per-field adjust, 12/24h formatting and an alarm FSM.
module watch_timekeeper
  import watch_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 100,
  parameter int RST_HOUR = 12,
  parameter int RING_SEC = 30
) (
  input  logic                clk,
  input  logic                rst,
  watch_timekeeper_if.slave   bus
);
  localparam int MSW = $clog2(TICK_HZ);
  localparam logic [MSW-1:0] MS_MAX    = MSW'(TICK_HZ - 1);
  localparam logic [5:0]     RING_LAST = 6'(RING_SEC - 1);

  logic tick;

  watch_tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en_i   (bus.i_run),
    .tick_o (tick)
  );

  logic [MSW-1:0] msec_q, msec_d;
  logic [5:0]     sec_q, sec_d, min_q, min_d, alm_min_q, alm_min_d;
  logic [4:0]     hour_q, hour_d, alm_hour_q, alm_hour_d;
  logic           pend_q, pend_d, sec_tick_q;
  alm_state_e     st_q, st_d;
  logic [5:0]     rcnt_q, rcnt_d;

  logic adj, t_adj, a_adj, adv, sec_cy, min_cy, hour_cy, match;

  assign adj     = (bus.i_up ^ bus.i_down) && (bus.i_sel != SEL_NONE);
  assign t_adj   = adj && !bus.i_target;
  assign a_adj   = adj && bus.i_target && (bus.i_sel != SEL_SEC);
  // A time adjust blocks the cascade; the tick is held in pend_q instead.
  assign adv     = !t_adj && (tick || pend_q);
  assign sec_cy  = adv && (msec_q == MS_MAX);
  assign min_cy  = sec_cy && (sec_q == SEC_MAX);
  assign hour_cy = min_cy && (min_q == MIN_MAX);

  always_comb begin
    msec_d     = msec_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    alm_min_d  = alm_min_q;
    alm_hour_d = alm_hour_q;
    pend_d     = t_adj ? (pend_q | tick) : (pend_q & tick);
    if (adv) begin
      msec_d = sec_cy ? '0 : msec_q + MSW'(1);
      if (sec_cy)  sec_d  = step(sec_q, SEC_MAX, 1'b1);
      if (min_cy)  min_d  = step(min_q, MIN_MAX, 1'b1);
      if (hour_cy) hour_d = 5'(step({1'b0, hour_q}, {1'b0, HOUR_MAX}, 1'b1));
    end
    if (t_adj) begin
      case (bus.i_sel)
        SEL_SEC: begin
          sec_d  = step(sec_q, SEC_MAX, bus.i_up);
          msec_d = '0;
        end
        SEL_MIN:  min_d  = step(min_q, MIN_MAX, bus.i_up);
        SEL_HOUR: hour_d = 5'(step({1'b0, hour_q}, {1'b0, HOUR_MAX}, bus.i_up));
        default: ;
      endcase
    end
    if (a_adj) begin
      case (bus.i_sel)
        SEL_MIN:  alm_min_d  = step(alm_min_q, MIN_MAX, bus.i_up);
        SEL_HOUR: alm_hour_d = 5'(step({1'b0, alm_hour_q}, {1'b0, HOUR_MAX}, bus.i_up));
        default: ;
      endcase
    end
  end

  // Only a cascade landing on hh:mm:00.00 counts; adjusting onto it never does.
  assign match = sec_cy && (sec_d == 6'd0) && (min_d == alm_min_q) && (hour_d == alm_hour_q);

  always_comb begin
    st_d   = st_q;
    rcnt_d = rcnt_q;
    case (st_q)
      ALM_OFF:   if (bus.i_alarm_en) st_d = ALM_ARMED;
      ALM_ARMED: if (match) begin
        st_d   = ALM_RING;
        rcnt_d = '0;
      end
      ALM_RING: begin
        if (bus.i_alarm_ack) st_d = ALM_ARMED;
        else if (sec_cy) begin
          if (rcnt_q == RING_LAST) st_d = ALM_ARMED;
          else                     rcnt_d = rcnt_q + 6'd1;
        end
      end
      default: st_d = ALM_OFF;
    endcase
    if (!bus.i_alarm_en) st_d = ALM_OFF;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msec_q     <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= 5'(RST_HOUR);
      alm_min_q  <= '0;
      alm_hour_q <= '0;
      pend_q     <= 1'b0;
      sec_tick_q <= 1'b0;
      st_q       <= ALM_OFF;
      rcnt_q     <= '0;
    end else begin
      msec_q     <= msec_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      alm_min_q  <= alm_min_d;
      alm_hour_q <= alm_hour_d;
      pend_q     <= pend_d;
      sec_tick_q <= sec_cy;
      st_q       <= st_d;
      rcnt_q     <= rcnt_d;
    end
  end

  assign bus.o_msec     = msec_q;
  assign bus.o_sec      = sec_q;
  assign bus.o_min      = min_q;
  assign bus.o_hour     = fmt_hour(hour_q, bus.i_mode12);
  assign bus.o_pm       = (hour_q >= 5'd12);
  assign bus.o_alm_min  = alm_min_q;
  assign bus.o_alm_hour = fmt_hour(alm_hour_q, bus.i_mode12);
  assign bus.o_ring     = (st_q == ALM_RING);
  assign bus.o_sec_tick = sec_tick_q;

endmodule

// File: tb/tb_watch_timekeeper.sv
// Vector table plus hand sequences for rollover, collision and alarm corner cases.
module tb_watch_timekeeper;
  import watch_pkg::*;

  localparam int CLK_HZ   = 1000;
  localparam int TICK_HZ  = 100;
  localparam int RING_SEC = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  watch_timekeeper_if #(.TICK_HZ(TICK_HZ)) bus  ();
  watch_timekeeper_if #(.TICK_HZ(TICK_HZ)) bus0 ();

  watch_timekeeper #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .RST_HOUR(12), .RING_SEC(RING_SEC))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));
  watch_timekeeper #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .RST_HOUR(0), .RING_SEC(RING_SEC))
    dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

  typedef struct { string nm; int v; } sb_t;
  sb_t sb_q[$];
  int  ntest = 0;
  int  nfail = 0;

  typedef struct {
    int         ticks;
    logic       tgt;
    logic [1:0] sel;
    logic       up, dn;
    int         h, m, s, ms, ah, am;
  } vec_t;
  vec_t vt[12];

  task automatic push(input string nm, input int v);
    sb_t e;
    e.nm = nm; e.v = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp(input int act);
    sb_t e;
    ntest++;
    if (sb_q.size() == 0) begin
      nfail++;
      $display("FAIL sb_empty: got %0d with no expected entry", act);
      return;
    end
    e = sb_q.pop_front();
    if (act != e.v) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", e.nm, act, e.v);
    end
  endtask

  task automatic chk(input string nm, input int act, input int e);
    push(nm, e);
    pop_cmp(act);
  endtask

  task automatic exp_time(input string nm, input int h, input int m, input int s, input int ms);
    push({nm, ".hour"}, h); push({nm, ".min"}, m); push({nm, ".sec"}, s); push({nm, ".msec"}, ms);
  endtask

  task automatic cmp_time();
    pop_cmp(int'(bus.o_hour)); pop_cmp(int'(bus.o_min));
    pop_cmp(int'(bus.o_sec));  pop_cmp(int'(bus.o_msec));
  endtask

  task automatic idle();
    bus.i_target = 1'b0; bus.i_sel = SEL_NONE; bus.i_up = 1'b0; bus.i_down = 1'b0;
    bus.i_alarm_ack = 1'b0;
  endtask

  task automatic pulse(input logic tgt, input logic [1:0] sel, input logic up, input logic dn);
    bus.i_target = tgt; bus.i_sel = sel; bus.i_up = up; bus.i_down = dn;
    @(negedge clk);
    idle();
  endtask

  task automatic run_cycles(input int n);
    bus.i_run = 1'b1;
    repeat (n) @(negedge clk);
    bus.i_run = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    bus.i_run = 1'b0; bus.i_mode12 = 1'b0; bus.i_alarm_en = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // From 00:01:00.00 step back to 00:00:59.00 so 100 ticks land on alarm 00:01.
  task automatic back_to_match();
    pulse(1'b0, SEL_SEC, 1'b0, 1'b1);
    pulse(1'b0, SEL_MIN, 1'b0, 1'b1);
  endtask

  initial begin
    bus0.i_run = 1'b0; bus0.i_target = 1'b0; bus0.i_sel = SEL_NONE; bus0.i_up = 1'b0;
    bus0.i_down = 1'b0; bus0.i_mode12 = 1'b1; bus0.i_alarm_en = 1'b0; bus0.i_alarm_ack = 1'b0;

    vt[0]  = '{0, 1'b0, SEL_NONE, 1'b1, 1'b0, 12,  0,  0, 0,  0,  0};
    vt[1]  = '{0, 1'b0, SEL_SEC,  1'b0, 1'b1, 12,  0, 59, 0,  0,  0};
    vt[2]  = '{7, 1'b0, SEL_SEC,  1'b1, 1'b0, 12,  0,  0, 0,  0,  0};
    vt[3]  = '{0, 1'b0, SEL_MIN,  1'b0, 1'b1, 12, 59,  0, 0,  0,  0};
    vt[4]  = '{0, 1'b0, SEL_MIN,  1'b1, 1'b0, 12,  0,  0, 0,  0,  0};
    vt[5]  = '{3, 1'b0, SEL_HOUR, 1'b1, 1'b0, 13,  0,  0, 3,  0,  0};
    vt[6]  = '{0, 1'b0, SEL_MIN,  1'b1, 1'b1, 13,  0,  0, 3,  0,  0};
    vt[7]  = '{0, 1'b1, SEL_SEC,  1'b1, 1'b0, 13,  0,  0, 3,  0,  0};
    vt[8]  = '{0, 1'b1, SEL_HOUR, 1'b0, 1'b1, 13,  0,  0, 3, 23,  0};
    vt[9]  = '{0, 1'b1, SEL_MIN,  1'b0, 1'b1, 13,  0,  0, 3, 23, 59};
    vt[10] = '{0, 1'b1, SEL_HOUR, 1'b1, 1'b0, 13,  0,  0, 3,  0, 59};
    vt[11] = '{0, 1'b1, SEL_MIN,  1'b1, 1'b0, 13,  0,  0, 3,  0,  0};

    do_reset();
    exp_time("reset", 12, 0, 0, 0);
    cmp_time();
    chk("reset.pm", int'(bus.o_pm), 1);
    chk("reset.ring", int'(bus.o_ring), 0);
    chk("reset.sec_tick", int'(bus.o_sec_tick), 0);
    chk("reset0.hour12", int'(bus0.o_hour), 12);
    chk("reset0.pm", int'(bus0.o_pm), 0);

    foreach (vt[i]) begin
      if (vt[i].ticks > 0) run_cycles(vt[i].ticks * 10);
      bus.i_target = vt[i].tgt; bus.i_sel = vt[i].sel; bus.i_up = vt[i].up; bus.i_down = vt[i].dn;
      exp_time($sformatf("vec%0d", i), vt[i].h, vt[i].m, vt[i].s, vt[i].ms);
      push($sformatf("vec%0d.alm_hour", i), vt[i].ah);
      push($sformatf("vec%0d.alm_min", i), vt[i].am);
      push($sformatf("vec%0d.sec_tick", i), 0);
      @(negedge clk);
      idle();
      cmp_time();
      pop_cmp(int'(bus.o_alm_hour));
      pop_cmp(int'(bus.o_alm_min));
      pop_cmp(int'(bus.o_sec_tick));
    end

    // 12h formatting and hour down-wrap; time is 13:00:00.03
    bus.i_mode12 = 1'b1;
    @(negedge clk);
    chk("fmt13.hour", int'(bus.o_hour), 1);
    chk("fmt13.pm", int'(bus.o_pm), 1);
    pulse(1'b0, SEL_HOUR, 1'b0, 1'b1);
    chk("fmt12.hour", int'(bus.o_hour), 12);
    chk("fmt12.pm", int'(bus.o_pm), 1);
    repeat (12) pulse(1'b0, SEL_HOUR, 1'b0, 1'b1);
    chk("fmt0.hour", int'(bus.o_hour), 12);
    chk("fmt0.pm", int'(bus.o_pm), 0);
    chk("fmt0.alm_hour", int'(bus.o_alm_hour), 12);
    bus.i_mode12 = 1'b0;
    @(negedge clk);
    chk("h24_0.hour", int'(bus.o_hour), 0);
    pulse(1'b0, SEL_HOUR, 1'b0, 1'b1);
    chk("hwrap.hour", int'(bus.o_hour), 23);
    chk("hwrap.min", int'(bus.o_min), 0);
    bus.i_mode12 = 1'b1;
    @(negedge clk);
    chk("fmt23.hour", int'(bus.o_hour), 11);
    chk("fmt23.pm", int'(bus.o_pm), 1);

    // Full rollover 23:59:59.99 -> 00:00:00.00
    do_reset();
    repeat (11) pulse(1'b0, SEL_HOUR, 1'b1, 1'b0);
    pulse(1'b0, SEL_MIN, 1'b0, 1'b1);
    pulse(1'b0, SEL_SEC, 1'b0, 1'b1);
    chk("adj.no_sec_tick", int'(bus.o_sec_tick), 0);
    run_cycles(990);
    exp_time("pre_roll", 23, 59, 59, 99);
    cmp_time();
    bus.i_run = 1'b1;
    repeat (9) @(negedge clk);
    exp_time("pre_roll9", 23, 59, 59, 99);
    cmp_time();
    chk("pre_roll9.sec_tick", int'(bus.o_sec_tick), 0);
    @(negedge clk);
    bus.i_run = 1'b0;
    exp_time("roll", 0, 0, 0, 0);
    cmp_time();
    chk("roll.pm", int'(bus.o_pm), 0);
    chk("roll.sec_tick", int'(bus.o_sec_tick), 1);
    @(negedge clk);
    chk("roll+1.sec_tick", int'(bus.o_sec_tick), 0);

    // Adjust on the divider-terminal cycle; pending tick must land next edge
    do_reset();
    bus.i_run = 1'b1;
    repeat (9) @(negedge clk);
    exp_time("coll_adj", 12, 1, 0, 0);
    pulse(1'b0, SEL_MIN, 1'b1, 1'b0);
    cmp_time();
    exp_time("coll_pend", 12, 1, 0, 1);
    @(negedge clk);
    cmp_time();
    repeat (989) @(negedge clk);
    bus.i_run = 1'b0;
    exp_time("coll_100", 12, 1, 1, 0);
    cmp_time();

    // Alarm at 00:01
    do_reset();
    bus.i_alarm_en = 1'b1;
    pulse(1'b1, SEL_MIN, 1'b1, 1'b0);
    repeat (12) pulse(1'b0, SEL_HOUR, 1'b0, 1'b1);
    pulse(1'b0, SEL_SEC, 1'b0, 1'b1);
    chk("alm.set_min", int'(bus.o_alm_min), 1);
    run_cycles(990);
    bus.i_run = 1'b1;
    repeat (9) @(negedge clk);
    chk("alm.pre_ring", int'(bus.o_ring), 0);
    @(negedge clk);
    bus.i_run = 1'b0;
    chk("alm.ring", int'(bus.o_ring), 1);
    exp_time("alm.time", 0, 1, 0, 0);
    cmp_time();
    bus.i_alarm_ack = 1'b1;
    @(negedge clk);
    bus.i_alarm_ack = 1'b0;
    chk("alm.ack", int'(bus.o_ring), 0);

    // Ring timeout after RING_SEC carries
    back_to_match();
    run_cycles(1000);
    chk("tmo.ring", int'(bus.o_ring), 1);
    run_cycles(RING_SEC * 1000 - 10);
    chk("tmo.before", int'(bus.o_ring), 1);
    run_cycles(10);
    chk("tmo.after", int'(bus.o_ring), 0);
    chk("tmo.sec", int'(bus.o_sec), RING_SEC);

    // Disable during ring, no re-ring while disabled, ring again after re-enable
    repeat (RING_SEC + 1) pulse(1'b0, SEL_SEC, 1'b0, 1'b1);
    pulse(1'b0, SEL_MIN, 1'b0, 1'b1);
    run_cycles(1000);
    chk("dis.ring", int'(bus.o_ring), 1);
    bus.i_alarm_en = 1'b0;
    @(negedge clk);
    chk("dis.off", int'(bus.o_ring), 0);
    back_to_match();
    run_cycles(1000);
    chk("dis.no_rering", int'(bus.o_ring), 0);
    bus.i_alarm_en = 1'b1;
    @(negedge clk);
    back_to_match();
    run_cycles(1000);
    chk("reen.ring", int'(bus.o_ring), 1);

    // Asynchronous reset mid-ring
    #2 rst = 1'b0;
    #1;
    chk("arst.ring", int'(bus.o_ring), 0);
    chk("arst.hour", int'(bus.o_hour), 12);
    @(negedge clk);
    rst = 1'b1;

    if (sb_q.size() != 0) begin
      ntest++;
      nfail++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule

// File: doc/watch_timekeeper.md
Name: watch_timekeeper

Overview:
Parametrised time-of-day core with alarm; replaces the fixed watch datapath behind the watch control unit and feeds fnd_controller. It counts centiseconds, seconds, minutes and hours from a divided system clock. It supports per-field up/down adjustment of either the live time or an alarm register, and a 12/24-hour display mode. It adds an alarm FSM with acknowledge and ring timeout.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz.
TICK_HZ, 100, sub-second counting rate; the msec field runs 0..TICK_HZ-1.
RST_HOUR, 12, hour value loaded into the time register at reset (0..23).
RING_SEC, 30, maximum ring duration in seconds before auto-stop (1..59).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (asserted when 0)
i_run  in  1  1 = time advances; 0 = time frozen (adjust still allowed)
i_target  in  1  0 = adjust time register, 1 = adjust alarm register
i_sel  in  2  field select: 0 = sec, 1 = min, 2 = hour, 3 = none
i_up  in  1  single-cycle debounced increment pulse
i_down  in  1  single-cycle debounced decrement pulse
i_mode12  in  1  1 = 12-hour display, 0 = 24-hour display
i_alarm_en  in  1  alarm enable level
i_alarm_ack  in  1  single-cycle pulse; stops ringing
o_msec  out  MSW=$clog2(TICK_HZ)  centisecond field
o_sec  out  6  seconds
o_min  out  6  minutes
o_hour  out  5  hour, formatted per i_mode12
o_pm  out  1  1 when internal hour >= 12, in both modes
o_alm_min  out  6  alarm minutes, for display while editing
o_alm_hour  out  5  alarm hour, formatted per i_mode12
o_ring  out  1  alarm ringing
o_sec_tick  out  1  one-cycle pulse on every seconds increment

Behaviour:
- Reset (rst=0, async): tick divider = 0; msec, sec, min = 0; hour = RST_HOUR; alarm = 00:00; alarm FSM = OFF; tick_pending = 0; o_ring = 0; o_sec_tick = 0.
- Divider: DIV = CLK_HZ/TICK_HZ. The counter runs 0..DIV-1 only while i_run=1 and holds otherwise. An internal tick fires in the cycle where count = DIV-1.
- Cascade on tick: msec wraps TICK_HZ-1 -> 0 and carries to sec. sec wraps 59 -> 0 and carries to min. min wraps 59 -> 0 and carries to hour. hour wraps 23 -> 0. All registers update on the same edge.
- o_sec_tick pulses, registered, in the cycle after the edge where sec changes due to a carry. Adjustment does not pulse it.
- Adjust is applied on the edge where i_up or i_down =1 and i_sel != 3, to the register selected by i_target:
  - The selected field increments or decrements modulo its range (sec/min 60, hour 24).
  - There is no carry or borrow into other fields.
  - A time-sec adjust also clears msec to 0.
  - i_up and i_down both high: no change.
  - Alarm sec is not stored; sel=0 with i_target=1 is ignored.
- Adjust/tick collision on the time register: the adjust wins. The tick is latched in tick_pending and applied on the next edge that has no time adjust. At most one pending tick is held; a collision while tick_pending=1 drops that tick.
- Hour format in 12-hour mode: 0 -> 12, 1..12 -> unchanged, 13..23 -> h-12. Formatting is combinational from the registers; the stored hour is always 0..23.
- Alarm FSM states: OFF, ARMED, RING.
  - OFF -> ARMED when i_alarm_en=1.
  - ARMED -> RING on the cascade edge where time becomes alm_hour:alm_min:00.00. Adjusting time onto the match never triggers the alarm.
  - RING -> ARMED on i_alarm_ack, or after RING_SEC seconds have elapsed (counted with sec carries).
  - Any state -> OFF when i_alarm_en=0; this has priority over all other transitions.
  - o_ring = (state == RING), registered. i_alarm_ack outside RING is ignored.
  - Editing the alarm while in RING does not stop the ring.
- Reset mid-ring: o_ring drops immediately (asynchronous) and the FSM returns to OFF.

Decomposition:
- Package watch_pkg: field-select encodings (SEL_SEC, SEL_MIN, SEL_HOUR, SEL_NONE), alarm state enum, and range constants (SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23).
- Sub-module watch_tick_gen(CLK_HZ, TICK_HZ): divider with enable, producing the single-cycle tick. Wrap/adjust logic and the alarm FSM stay in watch_timekeeper.

Test Plan:
All runs use CLK_HZ=1000, TICK_HZ=100 (DIV=10).
- Reset release -> outputs show 12:00:00.00, o_ring=0. In 12h mode, release at RST_HOUR=0 shows hour 12 with o_pm=0.
- Rollover: preload 23:59:59.99, one tick -> 00:00:00.00 on the same edge, and o_sec_tick high exactly one cycle later.
- Adjust wrap: sec=59 with up and sel=0 -> sec=0, min unchanged, msec=0. hour=0 with down and sel=2 -> hour=23. Up and down together -> no change.
- Collision: assert up with sel=1 on the divider-terminal cycle -> min+1 on that edge; msec+1 on the next edge; no tick lost across 100 ticks.
- Alarm: set alarm 00:01, enable, time 00:00:59.99, one tick -> o_ring=1 the cycle after the edge. Ack pulse -> o_ring=0, FSM ARMED.
- Timeout/disable: ring without ack -> o_ring clears after exactly RING_SEC sec carries. Deasserting i_alarm_en during RING -> o_ring=0 next edge, and there is no re-ring at the next match until re-enabled.
